alu_li: RTL and testbench
=========================

ALU_LI -- requirements
Module: alu_li

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 Parameter ADD_PIPELINE_STAGES, default 1, add latency in cycles; legal range 1..15.
REQ-003 Parameter MUL_PIPELINE_STAGES, default 3, multiply latency in cycles; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 a_in  input  WIDTH  operand A, binary32.
REQ-007 b_in  input  WIDTH  operand B, binary32.
REQ-008 op_in  input  1  0 = add (A+B), 1 = multiply (A*B).
REQ-009 valid_in  input  1  upstream offers an operation.
REQ-010 ready_out  output  1  block can accept an operation.
REQ-011 result_out  output  WIDTH  binary32 result.
REQ-012 valid_out  output  1  result_out holds a valid result.
REQ-013 ready_in  input  1  downstream accepts the result.

Function
REQ-014 Input handshake: the operation is accepted on a rising edge where valid_in=1 and ready_out=1; a_in, b_in and op_in are captured on that edge.
REQ-015 One outstanding operation; no input pipelining.
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE: ready_out=1, valid_out=0; on accept, go to BUSY and load the latency counter with ADD_PIPELINE_STAGES or MUL_PIPELINE_STAGES according to the captured op.
REQ-018 BUSY: ready_out=0, valid_out=0; counter decrements each cycle.
REQ-019 BUSY -> DONE: after exactly L cycles, valid_out rises on the L-th rising edge after the accept edge, L being the latency of the captured op.
REQ-020 DONE: valid_out=1, ready_out=0; result_out constant while in DONE.
REQ-021 Output handshake: the result is consumed on a rising edge where valid_out=1 and ready_in=1; the FSM returns to IDLE on that edge.
REQ-022 ready_in=0 in DONE holds the state and result indefinitely; no data loss.
REQ-023 valid_in in BUSY or DONE is ignored; the input values are not captured.
REQ-024 ready_out and valid_out are registered-state decodes only, with no combinational path from valid_in or ready_in.
REQ-025 Add: IEEE-754 binary32 addition, round-to-nearest-even.
REQ-026 Multiply: IEEE-754 binary32 multiplication, round-to-nearest-even.
REQ-027 Subnormal inputs are flushed to signed zero; subnormal results are flushed to signed zero.
REQ-028 Exact-zero sum is +0 (0x00000000), except (-0)+(-0) = -0.
REQ-029 Overflow gives signed infinity: 0x7F800000 or 0xFF800000.
REQ-030 Any NaN input, inf-inf, or inf*0 gives canonical NaN 0x7FC00000.
REQ-031 inf plus a finite value gives that inf; inf times a nonzero finite value gives inf with sign = XOR of the operand signs.
REQ-032 Multiply sign = XOR of the operand signs, including zero results.
REQ-033 result_out holds its last value outside DONE.

Reset
REQ-034 While reset=0: FSM = IDLE, counter = 0, result_out = 0x00000000, valid_out = 0, ready_out = 1, asynchronously.
REQ-035 Reset asserted mid-BUSY or in DONE aborts the operation; no valid_out is produced for it.
REQ-036 After reset deasserts, the first accept behaves as from IDLE.

Verification
REQ-037 Add: A=0x40000000, B=0x40400000, op=0, ready_in=1 -> result_out=0x40A00000 (5.0); valid_out high 1 cycle after accept for 1 cycle; ready_out back high the next cycle.
REQ-038 Multiply: same operands, op=1 -> result_out=0x40C00000 (6.0); valid_out rises exactly 3 cycles after accept.
REQ-039 Backpressure: ready_in=0 during multiply 0x3FC00000*0x40000000 -> valid_out=1, result_out=0x40400000 held for 5 cycles; consumed one edge after ready_in=1; valid_in pulses during BUSY are ignored.
REQ-040 Special values: 0x3F800000+0xBF800000 -> 0x00000000; 0x7F800000*0x00000000 -> 0x7FC00000; 0x7F7FFFFF*0x40000000 -> 0x7F800000; 0x80000000+0x80000000 -> 0x80000000.
REQ-041 Reset mid-operation: reset=0 two cycles after a multiply accept -> ready_out=1, valid_out=0, result_out=0 immediately; no result later; the next add 2.0+3.0 returns 0x40A00000.

Source files
------------

// File: rtl/alu_li.sv
// Single-issue binary32 add/multiply unit with valid/ready handshakes on both sides.
// A down-counter models the add/multiply latency; arithmetic flushes subnormals and rounds to nearest even.
module alu_li #(
  parameter int WIDTH               = 32,
  parameter int ADD_PIPELINE_STAGES = 1,
  parameter int MUL_PIPELINE_STAGES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             op_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] result_out,
  output logic             valid_out,
  input  logic             ready_in
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0]  ADD_LAT = 4'(ADD_PIPELINE_STAGES);
  localparam logic [3:0]  MUL_LAT = 4'(MUL_PIPELINE_STAGES);
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Round a 24-bit significand with guard/sticky bits, then saturate or flush the exponent.
  function automatic logic [31:0] pack_rne(input logic s, input logic signed [9:0] e,
                                           input logic [23:0] m, input logic g, input logic st);
    logic [24:0]       m_r;
    logic signed [9:0] e_r;
    logic [22:0]       frac;
    m_r  = {1'b0, m} + {24'd0, g & (st | m[0])};
    e_r  = m_r[24] ? e + 10'sd1 : e;
    frac = m_r[24] ? 23'd0 : m_r[22:0];
    if (e_r >= 10'sd255)    return {s, 8'hFF, 23'd0};
    else if (e_r <= 10'sd0) return {s, 31'd0};
    else                    return {s, e_r[7:0], frac};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic              za, zb, ia, ib, na, nb, found;
    logic [31:0]       x, y;
    logic [7:0]        diff;
    logic [26:0]       mx, my, my_sh, norm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e;
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (na || nb)   return QNAN;
    if (ia && ib)   return (a[31] != b[31]) ? QNAN : a;
    if (ia)         return a;
    if (ib)         return b;
    if (za && zb)   return {a[31] & b[31], 31'd0};
    if (za)         return b;
    if (zb)         return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    diff = x[30:23] - y[30:23];
    mx   = {1'b1, x[22:0], 3'b000};
    my   = {1'b1, y[22:0], 3'b000};
    // Bits shifted out of the smaller operand collapse into a sticky LSB.
    if (diff >= 8'd27) my_sh = 27'd1;
    else               my_sh = (my >> diff) | {26'd0, |(my & ~(27'h7FF_FFFF << diff))};
    sum = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, my_sh} : {1'b0, mx} - {1'b0, my_sh};
    if (sum == 28'd0) return 32'd0;
    e = $signed({2'b00, x[30:23]});
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = e + 10'sd1;
    end else begin
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else        lz    = lz + 5'd1;
        end
      end
      norm = sum[26:0] << lz;
      e    = e - $signed({5'd0, lz});
    end
    return pack_rne(x[31], e, norm[26:3], norm[2], |norm[1:0]);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s, za, zb, ia, ib, na, nb;
    logic [47:0]       p;
    logic signed [9:0] e;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (na || nb)                   return QNAN;
    if ((ia && zb) || (ib && za))   return QNAN;
    if (ia || ib)                   return {s, 8'hFF, 23'd0};
    if (za || zb)                   return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) return pack_rne(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    else       return pack_rne(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             op_q, op_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: if (valid_in) begin
        a_d     = a_in;
        b_d     = b_in;
        op_d    = op_in;
        cnt_d   = op_in ? MUL_LAT : ADD_LAT;
        state_d = BUSY;
      end
      BUSY: if (cnt_q <= 4'd1) begin
        cnt_d    = 4'd0;
        result_d = op_q ? fp_mul(a_q, b_q) : fp_add(a_q, b_q);
        state_d  = DONE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      DONE: if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  // NOTE: operand registers are reset too; they are few, and it keeps reset state fully defined.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign ready_out  = (state_q == IDLE);
  assign valid_out  = (state_q == DONE);
  assign result_out = result_q;

endmodule

// File: tb/tb_alu_li.sv
// Scoreboard bench for alu_li: directed IEEE-754 corner cases plus random operands
// checked against a double-precision reference model, with backpressure and reset abort.
module tb_alu_li;

  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 3;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_in, b_in, result_out;
  logic        op_in, valid_in, ready_out, valid_out, ready_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  alu_li #(.WIDTH(32), .ADD_PIPELINE_STAGES(ADD_LAT), .MUL_PIPELINE_STAGES(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .op_in(op_in), .valid_in(valid_in),
    .ready_out(ready_out), .result_out(result_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // binary32 (subnormals flushed) to double, exactly.
  function automatic real f2d(input logic [31:0] f);
    if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction

  // double to binary32 with round-to-nearest-even, flush-to-zero and overflow to inf.
  function automatic logic [31:0] d2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rest;
    logic        up;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e    = int'({21'd0, d[62:52]}) - 896;
    m    = {2'b01, d[51:29]};
    rest = d[28:0];
    up   = rest[28] && ((rest[27:0] != 28'd0) || m[0]);
    m    = m + 25'(up);
    if (m[24]) begin
      e++;
      m = 25'h080_0000;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic an, bn, ai, bi, az, bz;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    if (an || bn) return QNAN;
    if (!op) begin
      if (ai && bi) return (a[31] == b[31]) ? a : QNAN;
      if (ai) return a;
      if (bi) return b;
      return d2f(f2d(a) + f2d(b));
    end
    if ((ai && bz) || (bi && az)) return QNAN;
    if (ai || bi) return {a[31] ^ b[31], 8'hFF, 23'd0};
    return d2f(f2d(a) * f2d(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       r[30:23] = 8'd0;
      1:       r[30:23] = 8'hFF;
      2:       r[30:23] = 8'($urandom_range(253, 254));
      3:       r[30:23] = 8'($urandom_range(1, 3));
      default: r[30:23] = 8'($urandom_range(110, 144));
    endcase
    return r;
  endfunction

  // One full transaction: accept, latency, optional backpressure, consume.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] exp, input int hold, input bit noise);
    int          lat;
    int          waited;
    logic [31:0] exp_r;
    waited = 0;
    while (!ready_out && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_out before accept", 32'(ready_out), 32'd1);
    ready_in = (hold == 0);
    a_in     = a;
    b_in     = b;
    op_in    = op;
    valid_in = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 40) begin
      if (noise) begin
        valid_in = 1'b1;
        a_in     = $urandom;
        b_in     = $urandom;
        op_in    = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    valid_in = 1'b0;
    check(op ? "mul latency" : "add latency", 32'(lat), op ? 32'(MUL_LAT) : 32'(ADD_LAT));
    check("ready_out in DONE", 32'(ready_out), 32'd0);
    exp_r = exp_q.pop_front();
    check("result", result_out, exp_r);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        valid_in = 1'b1;
        a_in     = $urandom;
      end
      @(posedge clk); #1;
      check("held valid_out", 32'(valid_out), 32'd1);
      check("held result", result_out, exp_r);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk); #1;
    check("valid_out after consume", 32'(valid_out), 32'd0);
    check("ready_out after consume", 32'(ready_out), 32'd1);
    check("result kept in IDLE", result_out, exp_r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic        op;
    int          seen;
    reset = 1'b0; a_in = '0; b_in = '0; op_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    #1;
    check("reset ready_out", 32'(ready_out), 32'd1);
    check("reset valid_out", 32'(valid_out), 32'd0);
    check("reset result_out", result_out, 32'd0);
    #21 reset = 1'b1;
    @(posedge clk); #1;

    do_op(32'h4000_0000, 32'h4040_0000, 1'b0, 32'h40A0_0000, 0, 1'b0);
    do_op(32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000, 0, 1'b0);
    do_op(32'h3FC0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 5, 1'b1);
    do_op(32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 0, 1'b0);
    do_op(32'h7F80_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000, 0, 1'b0);
    do_op(32'h7F7F_FFFF, 32'h4000_0000, 1'b1, 32'h7F80_0000, 0, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 0, 1'b0);
    do_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 0, 1'b0);
    do_op(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 0, 1'b0);
    do_op(32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 0, 1'b0);
    do_op(32'h8040_0000, 32'h3F80_0000, 1'b1, 32'h8000_0000, 0, 1'b0);
    do_op(32'h0080_0000, 32'h3F00_0000, 1'b1, 32'h0000_0000, 0, 1'b0);
    do_op(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 0, 1'b0);
    do_op(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 0, 1'b0);
    do_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 0, 1'b0);
    do_op(32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 0, 1'b0);
    do_op(32'h3F80_0000, 32'h8000_0000, 1'b0, 32'h3F80_0000, 0, 1'b0);
    do_op(32'h0080_0000, 32'h8080_0001, 1'b0, 32'h8000_0000, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a  = rand_fp();
      b  = rand_fp();
      op = 1'($urandom);
      if (!op && $urandom_range(0, 3) == 0) b = {~a[31], a[30:4], 4'($urandom)};
      do_op(a, b, op, model(a, b, op), int'($urandom_range(0, 2)), 1'($urandom));
    end

    // Abort a multiply two cycles after its accept.
    ready_in = 1'b1;
    a_in = 32'h4000_0000; b_in = 32'h4040_0000; op_in = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort ready_out", 32'(ready_out), 32'd1);
    check("abort valid_out", 32'(valid_out), 32'd0);
    check("abort result_out", result_out, 32'd0);
    #3 reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (valid_out) seen++;
    end
    check("no result after abort", 32'(seen), 32'd0);
    do_op(32'h4000_0000, 32'h4040_0000, 1'b0, 32'h40A0_0000, 0, 1'b0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
